div_seq_restoring: RTL and testbench

//  Sequential restoring divider for unsigned operands. It produces one quotient bit per clock.

---
 rtl/divizor_pkg.sv | 18 +
 rtl/div_step.sv | 23 ++
 rtl/div_seq_restoring.sv | 108 ++++++++++
 tb/tb_div_seq_restoring.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/divizor_pkg.sv
// Shared definitions for the Divizor datapath (divider, BCD and display stages).
package divizor_pkg;

  // Operand width; 6 bits matches the downstream binary-to-BCD converter (max 63).
  localparam int DIV_WIDTH = 6;

  // State encodings, shared so other stages can decode divider state if needed.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_FIN  = ST_FIN
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// then subtract the divisor if it fits.
module div_step
  import divizor_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_p,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_p,
  output logic             o_qbit
);

  // The shifted partial remainder needs WIDTH+1 bits for the compare; after a
  // conditional subtract the result is always below the divisor and fits WIDTH.
  logic [WIDTH:0] w_shift;

  assign w_shift = {i_p, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_divisor});
  assign o_p     = o_qbit ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_seq_restoring.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Start/busy/done handshake; results held until the next accepted start.
module div_seq_restoring
  import divizor_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       r_state, w_next;
  logic             w_accept;
  logic [WIDTH-1:0] r_dvd, r_dsr, r_p, r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot, r_rem;
  logic             r_done, r_dbz;
  logic [WIDTH-1:0] w_step_p;
  logic             w_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_p      (r_p),
    .i_bit    (r_dvd[r_cnt]),
    .i_divisor(r_dsr),
    .o_p      (w_step_p),
    .o_qbit   (w_qbit)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and start acceptance. A start seen while done is still high is
  // dropped so the next operation begins no earlier than the cycle after done.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !r_done) begin
          w_accept = 1'b1;
          w_next   = (i_divisor == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN:   if (r_cnt == '0) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, iteration registers and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dvd  <= '0;
      r_dsr  <= '0;
      r_p    <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_dvd <= i_dividend;
        r_dsr <= i_divisor;
        r_p   <= '0;
        r_q   <= '0;
        r_cnt <= CW'(WIDTH - 1);
        r_dbz <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_p <= w_step_p;
        r_q <= {r_q[WIDTH-2:0], w_qbit};
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end else if (r_state == S_FIN) begin
        r_done <= 1'b1;
        if (r_dsr == '0) begin
          r_quot <= '1;
          r_rem  <= r_dvd;
          r_dbz  <= 1'b1;
        end else begin
          r_quot <= r_q;
          r_rem  <= r_p;
        end
      end
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_quotient    = r_quot;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq_restoring.sv
// Directed and sweep checks for the sequential restoring divider.
module tb_div_seq_restoring;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [5:0] dividend, divisor;
  logic [5:0] quotient, remainder;
  logic       busy, done, dbz;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  div_seq_restoring #(.WIDTH(6)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_busy       (busy),
    .o_done       (done),
    .o_div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  // Issue one operation and follow it to done; returns the sampled results,
  // the done cycle index (1 = cycle after the accepting edge, 0 = timeout)
  // and the number of busy cycles seen before done.
  task automatic run_op(input logic [5:0] a, input logic [5:0] b,
                        output logic [5:0] q, output logic [5:0] r,
                        output logic z, output int lat, output int bcnt);
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = 6'($urandom); divisor = 6'($urandom);
    lat = 0; bcnt = 0; q = '0; r = '0; z = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        lat = k; q = quotient; r = remainder; z = dbz;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_por();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk_cnt++;
    if ({quotient, remainder, busy, done, dbz} !== 15'd0)
      $display("FAIL reset_por got q=%0d r=%0d b=%0b d=%0b z=%0b exp all 0", quotient, remainder, busy, done, dbz);
    else pass_cnt++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [5:0] q, r; logic z; int lat, bc;
    run_op(6'd45, 6'd7, q, r, z, lat, bc);
    chk_cnt++; if (lat !== 8) $display("FAIL basic_latency got %0d exp 8", lat); else pass_cnt++;
    chk_cnt++; if (bc !== 7)  $display("FAIL basic_busy_cycles got %0d exp 7", bc); else pass_cnt++;
    chk_cnt++; if (q !== 6'd6) $display("FAIL basic_quotient got %0d exp 6", q); else pass_cnt++;
    chk_cnt++; if (r !== 6'd3) $display("FAIL basic_remainder got %0d exp 3", r); else pass_cnt++;
    chk_cnt++; if (z !== 1'b0) $display("FAIL basic_dbz got %0b exp 0", z); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done got %0b exp 0", busy); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %0b exp 0", done); else pass_cnt++;
    chk_cnt++; if (quotient !== 6'd6 || remainder !== 6'd3)
      $display("FAIL basic_hold got q=%0d r=%0d exp q=6 r=3", quotient, remainder); else pass_cnt++;
  endtask

  task automatic test_reset_idle();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({quotient, remainder, busy, done, dbz} !== 15'd0)
      $display("FAIL reset_idle_async got q=%0d r=%0d b=%0b d=%0b z=%0b exp all 0", quotient, remainder, busy, done, dbz);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_patterns();
    logic [5:0] ta [3] = '{6'd63, 6'd5, 6'd42};
    logic [5:0] tb [3] = '{6'd1, 6'd9, 6'd42};
    logic [5:0] eq [3] = '{6'd63, 6'd0, 6'd1};
    logic [5:0] er [3] = '{6'd0, 6'd5, 6'd0};
    logic [5:0] q, r; logic z; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], q, r, z, lat, bc);
      chk_cnt++;
      if (q !== eq[i] || r !== er[i] || z !== 1'b0 || lat !== 8)
        $display("FAIL pattern_%0d_by_%0d got q=%0d r=%0d z=%0b lat=%0d exp q=%0d r=%0d z=0 lat=8",
                 ta[i], tb[i], q, r, z, lat, eq[i], er[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_zero();
    logic [5:0] q, r; logic z; int lat, bc;
    run_op(6'd20, 6'd0, q, r, z, lat, bc);
    chk_cnt++; if (lat !== 2) $display("FAIL dbz_latency got %0d exp 2", lat); else pass_cnt++;
    chk_cnt++; if (bc !== 1)  $display("FAIL dbz_busy_cycles got %0d exp 1", bc); else pass_cnt++;
    chk_cnt++; if (q !== 6'd63 || r !== 6'd20 || z !== 1'b1)
      $display("FAIL dbz_result got q=%0d r=%0d z=%0b exp q=63 r=20 z=1", q, r, z); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (dbz !== 1'b1) $display("FAIL dbz_held got %0b exp 1", dbz); else pass_cnt++;
    run_op(6'd9, 6'd3, q, r, z, lat, bc);
    chk_cnt++; if (q !== 6'd3 || r !== 6'd0 || z !== 1'b0 || lat !== 8)
      $display("FAIL dbz_then_9_3 got q=%0d r=%0d z=%0b lat=%0d exp q=3 r=0 z=0 lat=8", q, r, z, lat); else pass_cnt++;
  endtask

  // Second start during RUN is ignored; the held start then re-triggers only
  // in the cycle after done.
  task automatic test_back_to_back();
    int lat = 0, lat2 = 0;
    logic b9, b10;
    @(posedge clk); #1;
    start = 1'b1; dividend = 6'd45; divisor = 6'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin start = 1'b1; dividend = 6'd10; divisor = 6'd2; end
      if (done) begin lat = k; break; end
      @(posedge clk); #1;
    end
    chk_cnt++; if (lat !== 8 || quotient !== 6'd6 || remainder !== 6'd3)
      $display("FAIL b2b_first got lat=%0d q=%0d r=%0d exp lat=8 q=6 r=3", lat, quotient, remainder); else pass_cnt++;
    @(posedge clk); #1; b9 = busy;
    @(posedge clk); #1; b10 = busy;
    start = 1'b0;
    chk_cnt++; if (b9 !== 1'b0) $display("FAIL b2b_start_in_done_ignored busy got %0b exp 0", b9); else pass_cnt++;
    chk_cnt++; if (b10 !== 1'b1) $display("FAIL b2b_accept_after_done busy got %0b exp 1", b10); else pass_cnt++;
    for (int k = 10; k <= 30; k++) begin
      if (done) begin lat2 = k; break; end
      @(posedge clk); #1;
    end
    chk_cnt++; if (lat2 !== 17 || quotient !== 6'd5 || remainder !== 6'd0)
      $display("FAIL b2b_second got lat=%0d q=%0d r=%0d exp lat=17 q=5 r=0", lat2, quotient, remainder); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    logic seen = 1'b0;
    logic [5:0] q, r; logic z; int lat, bc;
    @(posedge clk); #1;
    start = 1'b1; dividend = 6'd50; divisor = 6'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 4; k++) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({quotient, remainder, busy, done, dbz} !== 15'd0)
      $display("FAIL reset_midop_outputs got q=%0d r=%0d b=%0b d=%0b z=%0b exp all 0", quotient, remainder, busy, done, dbz);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (done || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL reset_midop_no_done got activity=%0b exp 0", seen); else pass_cnt++;
    run_op(6'd50, 6'd6, q, r, z, lat, bc);
    chk_cnt++; if (q !== 6'd8 || r !== 6'd2 || lat !== 8)
      $display("FAIL reset_midop_rerun got q=%0d r=%0d lat=%0d exp q=8 r=2 lat=8", q, r, lat); else pass_cnt++;
  endtask

  task automatic test_sweep();
    logic [5:0] q, r, eq, er; logic z, ez; int lat, bc, elat, ebc;
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        run_op(6'(a), 6'(b), q, r, z, lat, bc);
        if (b == 0) begin eq = 6'd63; er = 6'(a); ez = 1'b1; elat = 2; ebc = 1; end
        else begin eq = 6'(a / b); er = 6'(a % b); ez = 1'b0; elat = 8; ebc = 7; end
        chk_cnt++;
        if (q !== eq || r !== er || z !== ez || lat !== elat || bc !== ebc)
          $display("FAIL sweep_%0d_by_%0d got q=%0d r=%0d z=%0b lat=%0d busy=%0d exp q=%0d r=%0d z=%0b lat=%0d busy=%0d",
                   a, b, q, r, z, lat, bc, eq, er, ez, elat, ebc);
        else pass_cnt++;
        if (b != 0) begin
          chk_cnt++;
          if (!(r < 6'(b))) $display("FAIL sweep_rem_lt_div %0d/%0d got r=%0d exp below %0d", a, b, r, b);
          else pass_cnt++;
        end
      end
    end
  endtask

  initial begin
    test_reset_por();
    test_basic();
    test_reset_idle();
    test_patterns();
    test_div_zero();
    test_back_to_back();
    test_reset_midop();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
